// File: rtl/port_sign_ext_accum_if.sv
// Handshake bundle for port_sign_ext_accum: run control, sample stream and result port.
// Master drives run control and samples; slave is the accumulator.
interface port_sign_ext_accum_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] count;
   logic             in_valid;
   logic             in_ready;
   logic             in_one;
   logic [1:0]       in_two;
   logic [31:0]      in_int;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      sum_one;
   logic [31:0]      sum_two;
   logic [31:0]      sum_int;
   logic [CNT_W+1:0] neg_count;
   logic             busy;

   modport master (
      output start, count, in_valid, in_one, in_two, in_int, out_ready,
      input  in_ready, out_valid, sum_one, sum_two, sum_int, neg_count, busy
   );

   modport slave (
      input  start, count, in_valid, in_one, in_two, in_int, out_ready,
      output in_ready, out_valid, sum_one, sum_two, sum_int, neg_count, busy
   );
endinterface

// File: rtl/port_sign_ext_accum.sv
// Three-lane sign/zero-extending accumulator: sums a run of samples per lane and counts
// negative extended values, then presents the result on a valid/ready port.
module port_sign_ext_accum #(
   parameter bit          ONE_SIGNED = 1'b1,
   parameter bit          TWO_SIGNED = 1'b1,
   parameter bit          INT_SIGNED = 1'b1,
   parameter int unsigned CNT_W      = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   port_sign_ext_accum_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] remaining_q;
   logic [31:0]      sum_one_q;
   logic [31:0]      sum_two_q;
   logic [31:0]      sum_int_q;
   logic [CNT_W+1:0] neg_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [31:0]      ext_one;
   logic [31:0]      ext_two;
   logic [1:0]       neg_add;
   logic             xfer;

   always_comb begin
      ext_one = ONE_SIGNED ? {32{bus.in_one}} : {31'd0, bus.in_one};
      ext_two = TWO_SIGNED ? {{30{bus.in_two[1]}}, bus.in_two} : {30'd0, bus.in_two};
      // in_int is added as-is; its signedness only decides whether it counts as negative
      neg_add = 2'(ONE_SIGNED && bus.in_one) + 2'(TWO_SIGNED && bus.in_two[1])
              + 2'(INT_SIGNED && bus.in_int[31]);
      xfer    = bus.in_valid && in_ready_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         sum_one_q   <= '0;
         sum_two_q   <= '0;
         sum_int_q   <= '0;
         neg_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  sum_one_q <= '0;
                  sum_two_q <= '0;
                  sum_int_q <= '0;
                  neg_q     <= '0;
                  busy_q    <= 1'b1;
                  if (bus.count != '0) begin
                     remaining_q <= bus.count;
                     state_q     <= StAccum;
                     in_ready_q  <= 1'b1;
                  end else begin
                     state_q     <= StReport;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            StAccum: begin
               if (xfer) begin
                  sum_one_q   <= sum_one_q + ext_one;
                  sum_two_q   <= sum_two_q + ext_two;
                  sum_int_q   <= sum_int_q + bus.in_int;
                  neg_q       <= neg_q + {{CNT_W{1'b0}}, neg_add};
                  remaining_q <= remaining_q - 1'b1;
                  if (remaining_q == CNT_W'(1)) begin
                     state_q     <= StReport;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            StReport: begin
               if (bus.out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.sum_one   = sum_one_q;
   assign bus.sum_two   = sum_two_q;
   assign bus.sum_int   = sum_int_q;
   assign bus.neg_count = neg_q;
endmodule
